ahb_fifo_write: RTL and testbench

AHB_FIFO_WRITE -- requirements
Module: ahb_fifo_write

---
 rtl/ahb_fifo_write.sv | 130 +++++++++++++
 tb/tb_ahb_fifo_write.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_fifo_write.sv
// ahb_fifo_write: JTAG data-register deserializer feeding a write FIFO.
// Frames shifted in on TDI during Shift-DR are framed as
// start(1), DATA_WIDTH payload bits LSB first, stop(0). A good frame produces
// one winc pulse carrying the payload. Frames that are dropped raise a sticky
// flag: overflow when the FIFO was full, frame_error when the stop bit was bad.
module ahb_fifo_write #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  TCK,
    input  logic                  n_rst,
    input  logic                  TDI,
    input  logic                  dr_shift,
    input  logic                  ahb_fifo_write_select,
    input  logic                  wfull,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  winc,
    output logic                  overflow,
    output logic                  frame_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] STOP = 2'd2;
    localparam logic [1:0] PUSH = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] payload_q, payload_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_error_q, frame_error_d;
    logic                  overflow_set, frame_error_set;
    logic                  active;
    logic [DATA_WIDTH:0]   shift_in;

    // TDI only counts while our data register is the one being shifted.
    assign active   = dr_shift & ahb_fifo_write_select;
    // New bits enter at the MSB so an LSB-first stream lands in order.
    assign shift_in = {TDI, payload_q};

    // Next-state logic for the frame parser; inactive cycles freeze the frame.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        payload_d       = payload_q;
        wdata_d         = wdata_q;
        overflow_set    = 1'b0;
        frame_error_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (active && TDI) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (active) begin
                    payload_d = shift_in[DATA_WIDTH:1];
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (active) begin
                    if (TDI) begin
                        // A 1 here is a broken stop bit, never a start bit.
                        frame_error_set = 1'b1;
                        state_d         = IDLE;
                    end else if (wfull) begin
                        overflow_set = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        wdata_d = payload_q;
                        state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                // Leave PUSH every time; a start bit here begins the next frame.
                if (active && TDI) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky flags: a set in the same cycle as err_clear takes priority.
    always_comb begin
        overflow_d    = overflow_set    | (overflow_q    & ~err_clear);
        frame_error_d = frame_error_set | (frame_error_q & ~err_clear);
    end

    // State registers; reset discards any partially received frame.
    always_ff @(posedge TCK or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            payload_q     <= '0;
            wdata_q       <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            payload_q     <= payload_d;
            wdata_q       <= wdata_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    // winc decodes the registered state only, so TDI never reaches it directly.
    assign winc        = (state_q == PUSH);
    assign wdata       = wdata_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ahb_fifo_write.sv
// Testbench for ahb_fifo_write: directed scenarios followed by random frames,
// checked against a frame-level model of pushes and sticky flags.
module tb_ahb_fifo_write;

    localparam int W = 8;

    logic         TCK = 1'b0;
    logic         n_rst;
    logic         TDI;
    logic         dr_shift;
    logic         ahb_fifo_write_select;
    logic         wfull;
    logic         err_clear;
    logic [W-1:0] wdata;
    logic         winc;
    logic         overflow;
    logic         frame_error;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model: last pushed payload and the two sticky flags.
    logic [W-1:0] m_wdata;
    logic         m_ovf;
    logic         m_ferr;

    ahb_fifo_write #(.DATA_WIDTH(W)) dut (
        .TCK                   (TCK),
        .n_rst                 (n_rst),
        .TDI                   (TDI),
        .dr_shift              (dr_shift),
        .ahb_fifo_write_select (ahb_fifo_write_select),
        .wfull                 (wfull),
        .err_clear             (err_clear),
        .wdata                 (wdata),
        .winc                  (winc),
        .overflow              (overflow),
        .frame_error           (frame_error)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_winc"}, {31'd0, winc}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, wdata}, {24'd0, m_wdata});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, m_ovf});
        chk({tag, "_ferr"}, {31'd0, frame_error}, {31'd0, m_ferr});
    endtask

    // One active bit inside a frame; no push may be visible afterwards.
    task automatic send_bit(input logic b, input string tag);
        TDI = b;
        dr_shift = 1'b1;
        ahb_fifo_write_select = 1'b1;
        step();
        chk(tag, {31'd0, winc}, 32'd0);
    endtask

    // Inactive cycles with random TDI: the frame must stay frozen.
    task automatic pause(input int n);
        for (int k = 0; k < n; k++) begin
            int r;
            r = $urandom_range(0, 2);
            dr_shift = (r == 1);
            ahb_fifo_write_select = (r == 2);
            TDI = 1'($urandom);
            step();
            chk("pause_winc", {31'd0, winc}, 32'd0);
        end
        dr_shift = 1'b1;
        ahb_fifo_write_select = 1'b1;
    endtask

    // Idle-line cycles (TDI=0), optionally clearing the sticky flags.
    task automatic idle(input int n, input logic clr);
        for (int k = 0; k < n; k++) begin
            TDI = 1'b0;
            dr_shift = 1'($urandom);
            ahb_fifo_write_select = 1'b1;
            err_clear = clr;
            step();
            if (clr) begin
                m_ovf  = 1'b0;
                m_ferr = 1'b0;
            end
            err_clear = 1'b0;
            chk_quiet("idle");
        end
    endtask

    // Whole frame; pause_after=k inserts an inactive gap after data bit k.
    task automatic send_frame(input logic [W-1:0] d, input logic stopb, input logic wf,
                              input int pause_after, input logic clr);
        logic good;
        send_bit(1'b1, "start_winc");
        for (int i = 0; i < W; i++) begin
            send_bit(d[i], "data_winc");
            if (i + 1 == pause_after) pause(5);
        end
        TDI = stopb;
        wfull = wf;
        err_clear = clr;
        dr_shift = 1'b1;
        ahb_fifo_write_select = 1'b1;
        step();
        good = !stopb && !wf;
        if (clr) begin
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end
        if (stopb) m_ferr = 1'b1;
        else if (wf) m_ovf = 1'b1;
        if (good) m_wdata = d;
        chk("stop_winc", {31'd0, winc}, {31'd0, good});
        chk("stop_wdata", {24'd0, wdata}, {24'd0, m_wdata});
        chk("stop_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        chk("stop_ferr", {31'd0, frame_error}, {31'd0, m_ferr});
        wfull = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        TDI = 1'b0;
        dr_shift = 1'b0;
        ahb_fifo_write_select = 1'b0;
        wfull = 1'b0;
        err_clear = 1'b0;
        m_wdata = '0;
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        #12;
        chk_quiet("reset");
        n_rst = 1'b1;
        step();
        chk_quiet("post_reset");

        // Single good frame 0xA5.
        send_frame(8'hA5, 1'b0, 1'b0, -1, 1'b0);
        idle(2, 1'b0);

        // Back-to-back 0x3C then 0xFF: start bit lands in the push cycle.
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, -1, 1'b0);
        idle(1, 1'b0);

        // FIFO full at the stop bit, then clear the overflow flag.
        send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
        idle(1, 1'b0);
        idle(1, 1'b1);

        // Bad stop bit, then a good frame straight after.
        send_frame(8'h81, 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, -1, 1'b0);
        idle(1, 1'b0);

        // Shift paused for 5 cycles after bit 4.
        send_frame(8'hC3, 1'b0, 1'b0, 4, 1'b0);
        idle(1, 1'b0);

        // Reset mid-frame after 3 data bits of 0xFF.
        send_bit(1'b1, "rst_start_winc");
        for (int i = 0; i < 3; i++) send_bit(1'b1, "rst_data_winc");
        #2;
        n_rst = 1'b0;
        #1;
        m_wdata = '0;
        m_ovf = 1'b0;
        m_ferr = 1'b0;
        chk_quiet("mid_reset");
        step();
        chk_quiet("mid_reset_hold");
        n_rst = 1'b1;
        send_frame(8'h12, 1'b0, 1'b0, -1, 1'b0);
        idle(2, 1'b0);

        // Random frames with errors, pauses, gaps and clears.
        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] d;
            int pa;
            d = W'($urandom);
            pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1;
            send_frame(d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                       pa, ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 2), ($urandom_range(0, 4) == 0));
        end
        idle(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
